// File: rtl/rggen_rtl_pkg.sv
// Shared rggen types: access status, transfer direction and the byte-strobe
// to bit-mask expansion used by every bus bridge in the library.
package rggen_rtl_pkg;

    typedef enum logic [1:0] {
        RGGEN_OKAY         = 2'b00,
        RGGEN_EXOKAY       = 2'b01,
        RGGEN_SLAVE_ERROR  = 2'b10,
        RGGEN_DECODE_ERROR = 2'b11
    } rggen_status;

    typedef enum logic {
        RGGEN_READ  = 1'b0,
        RGGEN_WRITE = 1'b1
    } rggen_direction;

    localparam int RGGEN_STATUS_WIDTH     = 2;
    // Widest data bus the mask helper handles; callers size-cast the result.
    localparam int RGGEN_MAX_DATA_WIDTH   = 1024;
    localparam int RGGEN_MAX_STROBE_WIDTH = RGGEN_MAX_DATA_WIDTH / 8;

    // Replicate every strobe bit across its 8-bit byte lane.
    function automatic logic [RGGEN_MAX_DATA_WIDTH-1:0] rggen_strobe_to_mask(
        input logic [RGGEN_MAX_STROBE_WIDTH-1:0] strobe
    );
        logic [RGGEN_MAX_DATA_WIDTH-1:0] mask;
        mask = '0;
        for (int i = 0; i < RGGEN_MAX_STROBE_WIDTH; i++) begin
            mask[8*i +: 8] = {8{strobe[i]}};
        end
        return mask;
    endfunction

endpackage

// File: rtl/rggen_bus_if.sv
// Host-side bus: request fields from the host, completion/response back.
interface rggen_bus_if
    import rggen_rtl_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 16,
    parameter int DATA_WIDTH    = 32
) ();
    logic                      request;
    logic [ADDRESS_WIDTH-1:0]  address;
    rggen_direction            direction;
    logic [DATA_WIDTH-1:0]     write_data;
    logic [DATA_WIDTH/8-1:0]   strobe;
    logic                      done;
    logic                      write_done;
    logic                      read_done;
    logic [DATA_WIDTH-1:0]     read_data;
    rggen_status               status;

    modport master (
        output request, address, direction, write_data, strobe,
        input  done, write_done, read_done, read_data, status
    );

    modport slave (
        input  request, address, direction, write_data, strobe,
        output done, write_done, read_done, read_data, status
    );
endinterface

// File: rtl/rggen_register_if.sv
// Per-register channel: broadcast access out, decode/handshake/response in.
interface rggen_register_if
    import rggen_rtl_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 16,
    parameter int DATA_WIDTH    = 32
) ();
    logic                      request;
    logic [ADDRESS_WIDTH-1:0]  address;
    rggen_direction            direction;
    logic [DATA_WIDTH-1:0]     write_data;
    logic [DATA_WIDTH/8-1:0]   write_strobe;
    logic [DATA_WIDTH-1:0]     write_mask;
    logic                      select;
    logic                      ready;
    logic [DATA_WIDTH-1:0]     read_data;
    rggen_status               status;

    modport master (
        output request, address, direction, write_data, write_strobe, write_mask,
        input  select, ready, read_data, status
    );

    modport slave (
        input  request, address, direction, write_data, write_strobe, write_mask,
        output select, ready, read_data, status
    );
endinterface

// File: rtl/rggen_onehot_mux.sv
// Priority select mux: the lowest-index asserted select wins, and a flag
// reports when more than one select is asserted at once.
module rggen_onehot_mux #(
    parameter int WIDTH   = 1,
    parameter int ENTRIES = 1
) (
    input  logic [ENTRIES-1:0]            i_select,
    input  logic [ENTRIES-1:0][WIDTH-1:0] i_data,
    output logic                          o_selected,
    output logic                          o_multi,
    output logic [WIDTH-1:0]              o_data
);
    localparam int INDEX_WIDTH = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

    // w_seen[i] is set when any select below index i is asserted.
    logic [ENTRIES:0]         w_seen;
    logic [ENTRIES-1:0]       w_overlap;
    logic [ENTRIES-1:0]       w_grant;
    logic [INDEX_WIDTH-1:0]   w_index;

    assign w_seen[0] = 1'b0;

    for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_prefix
        assign w_seen[gi+1]  = w_seen[gi] | i_select[gi];
        assign w_overlap[gi] = w_seen[gi] & i_select[gi];
    end

    // One-hot (or multi-hot) to binary, lowest asserted index wins.
    always_comb begin
        w_index = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (i_select[i]) begin
                w_index = INDEX_WIDTH'(i);
            end
        end
    end

    for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_grant
        assign w_grant[gi] = w_seen[ENTRIES] && (w_index == INDEX_WIDTH'(gi));
    end

    // AND-OR data selection driven by the single granted entry.
    always_comb begin
        o_data = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            o_data = o_data | ({WIDTH{w_grant[i]}} & i_data[i]);
        end
    end

    assign o_selected = w_seen[ENTRIES];
    assign o_multi    = |w_overlap;

endmodule

// File: rtl/rggen_bus_splitter_timed.sv
// Bus splitter: latches one host request, broadcasts it to every register
// channel, waits for the selected register's ready (with optional timeout)
// and returns a one-cycle completion with the captured response.
module rggen_bus_splitter_timed
    import rggen_rtl_pkg::*;
#(
    parameter int ADDRESS_WIDTH      = 16,
    parameter int DATA_WIDTH         = 32,
    parameter int TOTAL_REGISTERS    = 1,
    parameter int TIMEOUT_CYCLES     = 0,
    parameter int MULTI_SELECT_ERROR = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    rggen_bus_if.slave        bus_if,
    rggen_register_if.master  register_if [TOTAL_REGISTERS]
);
    typedef enum logic [1:0] {
        STATE_IDLE,
        STATE_ACCESS,
        STATE_RESPOND
    } state_e;

    localparam int STROBE_WIDTH  = DATA_WIDTH / 8;
    localparam int ENTRY_WIDTH   = 1 + RGGEN_STATUS_WIDTH + DATA_WIDTH;
    // A zero timeout still keeps a 1-bit counter so the datapath stays legal.
    localparam int COUNTER_WIDTH = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [COUNTER_WIDTH-1:0] TIMEOUT_VALUE = COUNTER_WIDTH'(TIMEOUT_CYCLES);
    localparam logic [COUNTER_WIDTH-1:0] COUNTER_MAX   = '1;

    state_e                         r_state;
    state_e                         w_state_next;
    logic [ADDRESS_WIDTH-1:0]       r_address;
    rggen_direction                 r_direction;
    logic [DATA_WIDTH-1:0]          r_write_data;
    logic [STROBE_WIDTH-1:0]        r_write_strobe;
    logic [COUNTER_WIDTH-1:0]       r_wait_count;
    logic [COUNTER_WIDTH-1:0]       w_wait_count_next;
    logic [DATA_WIDTH-1:0]          r_read_data;
    logic [DATA_WIDTH-1:0]          w_read_data_next;
    rggen_status                    r_status;
    rggen_status                    w_status_next;
    logic                           w_load_request;

    logic                           w_access;
    logic                           w_respond;
    logic [DATA_WIDTH-1:0]          w_write_mask;

    logic [TOTAL_REGISTERS-1:0]                  w_select;
    logic [TOTAL_REGISTERS-1:0][ENTRY_WIDTH-1:0] w_entry;
    logic [ENTRY_WIDTH-1:0]         w_selected_entry;
    logic                           w_any_select;
    logic                           w_multi_select;
    logic                           w_selected_ready;
    rggen_status                    w_selected_status;
    logic [DATA_WIDTH-1:0]          w_selected_data;

    assign w_access     = (r_state == STATE_ACCESS);
    assign w_respond    = (r_state == STATE_RESPOND);
    assign w_write_mask = DATA_WIDTH'(rggen_strobe_to_mask(RGGEN_MAX_STROBE_WIDTH'(r_write_strobe)));

    // Broadcast the latched access; gather each channel's response bundle.
    for (genvar gi = 0; gi < TOTAL_REGISTERS; gi++) begin : g_channel
        assign register_if[gi].request      = w_access;
        assign register_if[gi].address      = r_address;
        assign register_if[gi].direction    = r_direction;
        assign register_if[gi].write_data   = r_write_data;
        assign register_if[gi].write_strobe = r_write_strobe;
        assign register_if[gi].write_mask   = w_write_mask;
        assign w_select[gi] = register_if[gi].select;
        assign w_entry[gi]  = {register_if[gi].ready, register_if[gi].status, register_if[gi].read_data};
    end

    rggen_onehot_mux #(
        .WIDTH   (ENTRY_WIDTH),
        .ENTRIES (TOTAL_REGISTERS)
    ) u_select_mux (
        .i_select   (w_select),
        .i_data     (w_entry),
        .o_selected (w_any_select),
        .o_multi    (w_multi_select),
        .o_data     (w_selected_entry)
    );

    assign w_selected_ready  = w_selected_entry[ENTRY_WIDTH-1];
    assign w_selected_status = rggen_status'(w_selected_entry[DATA_WIDTH +: RGGEN_STATUS_WIDTH]);
    assign w_selected_data   = w_selected_entry[DATA_WIDTH-1:0];

    // Next-state, request latch enable, wait counting and response capture.
    always_comb begin
        w_state_next      = r_state;
        w_load_request    = 1'b0;
        w_wait_count_next = r_wait_count;
        w_read_data_next  = r_read_data;
        w_status_next     = r_status;
        case (r_state)
            STATE_IDLE: begin
                if (bus_if.request) begin
                    w_state_next      = STATE_ACCESS;
                    w_load_request    = 1'b1;
                    w_wait_count_next = '0;
                end
            end
            STATE_ACCESS: begin
                if (!w_any_select) begin
                    w_state_next     = STATE_RESPOND;
                    w_read_data_next = '0;
                    w_status_next    = RGGEN_DECODE_ERROR;
                end else if ((MULTI_SELECT_ERROR != 0) && w_multi_select) begin
                    w_state_next     = STATE_RESPOND;
                    w_read_data_next = '0;
                    w_status_next    = RGGEN_SLAVE_ERROR;
                end else if (w_selected_ready) begin
                    // A late ready still wins over an expiring timeout.
                    w_state_next     = STATE_RESPOND;
                    w_read_data_next = w_selected_data;
                    w_status_next    = w_selected_status;
                end else if ((TIMEOUT_CYCLES > 0) && (r_wait_count == TIMEOUT_VALUE)) begin
                    w_state_next     = STATE_RESPOND;
                    w_read_data_next = '0;
                    w_status_next    = RGGEN_SLAVE_ERROR;
                end else if (r_wait_count != COUNTER_MAX) begin
                    w_wait_count_next = r_wait_count + COUNTER_WIDTH'(1);
                end
            end
            STATE_RESPOND: begin
                w_state_next = STATE_IDLE;
            end
            default: begin
                w_state_next = STATE_IDLE;
            end
        endcase
    end

    // State, latched request fields, wait counter and captured response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= STATE_IDLE;
            r_address      <= '0;
            r_direction    <= RGGEN_READ;
            r_write_data   <= '0;
            r_write_strobe <= '0;
            r_wait_count   <= '0;
            r_read_data    <= '0;
            r_status       <= RGGEN_OKAY;
        end else begin
            r_state      <= w_state_next;
            r_wait_count <= w_wait_count_next;
            r_read_data  <= w_read_data_next;
            r_status     <= w_status_next;
            if (w_load_request) begin
                r_address      <= bus_if.address;
                r_direction    <= bus_if.direction;
                r_write_data   <= bus_if.write_data;
                r_write_strobe <= bus_if.strobe;
            end
        end
    end

    assign bus_if.done       = w_respond;
    assign bus_if.write_done = w_respond && (r_direction == RGGEN_WRITE);
    assign bus_if.read_done  = w_respond && (r_direction == RGGEN_READ);
    assign bus_if.read_data  = w_respond ? r_read_data : '0;
    assign bus_if.status     = w_respond ? r_status : RGGEN_OKAY;

endmodule

// File: doc/rggen_bus_splitter_timed.md
RGGEN_BUS_SPLITTER_TIMED -- requirements
Module: rggen_bus_splitter_timed

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning bus data width in bits (multiple of 8).
REQ-002 SHALL have parameter TOTAL_REGISTERS, default 1, meaning number of register_if channels (>=1).
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 0, meaning max wait cycles before SLAVE_ERROR; 0 disables the timeout.
REQ-004 SHALL have parameter MULTI_SELECT_ERROR, default 1, meaning >1 select asserted yields SLAVE_ERROR; 0 means lowest index wins.
REQ-005 SHALL have port clk  input  1  clock, single clock domain.
REQ-006 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-007 SHALL have port bus_if  rggen_bus_if.slave  -  host request plus done/read_done/write_done/read_data/status.
REQ-008 SHALL have port register_if  rggen_register_if.master [TOTAL_REGISTERS]  -  per-register request/address/direction/write_data/write_strobe/write_mask out; select/ready/read_data/status in.

Function
REQ-009 SHALL implement FSM states IDLE, ACCESS, RESPOND.
REQ-010 IDLE: on bus_if.request=1, SHALL latch address, direction, write_data, write_strobe into a request register and go to ACCESS next cycle.
REQ-011 ACCESS: SHALL drive register_if[*].request=1 and the latched fields to all channels; request=0 in IDLE and RESPOND.
REQ-012 write_mask SHALL be each write_strobe bit replicated over its 8-bit byte lane.
REQ-013 ACCESS, no select asserted: SHALL capture read_data=0, status=RGGEN_DECODE_ERROR in that cycle and go to RESPOND.
REQ-014 ACCESS, exactly one select asserted with its ready=1: SHALL capture that channel's read_data/status and go to RESPOND.
REQ-015 ACCESS, >1 select asserted and MULTI_SELECT_ERROR=1: SHALL capture read_data=0, status=RGGEN_SLAVE_ERROR without waiting for ready; if 0, lowest-index selected channel is treated per REQ-014.
REQ-016 Selected channel with ready=0: SHALL stay in ACCESS, increment wait counter (width clog2(TIMEOUT_CYCLES+1), saturating).
REQ-017 TIMEOUT_CYCLES>0 and counter==TIMEOUT_CYCLES with ready still 0: SHALL capture read_data=0, status=RGGEN_SLAVE_ERROR and go to RESPOND; ready arriving in that same cycle SHALL take priority (normal response).
REQ-018 RESPOND: SHALL assert done=1 for exactly one cycle, write_done=direction==WRITE, read_done=direction==READ, drive captured read_data/status, then return to IDLE.
REQ-019 Outside RESPOND, done/read_done/write_done SHALL be 0, read_data 0, status RGGEN_OKAY.
REQ-020 Latency: zero-wait register -> request sampled cycle N, done in cycle N+2; each ready wait cycle adds one.
REQ-021 A new request SHALL NOT be accepted in RESPOND; earliest acceptance is the IDLE cycle after done.
REQ-022 Deassertion of bus_if.request during ACCESS SHALL be ignored; the transfer completes using latched fields.
REQ-023 Wait counter SHALL clear on entry to ACCESS.

Reset
REQ-024 rst_n=0 SHALL asynchronously force state IDLE, counter 0, latched request fields 0, done/read_done/write_done 0, read_data 0, status RGGEN_OKAY, register_if request 0.
REQ-025 Reset mid-ACCESS/RESPOND SHALL abort the transfer with no done pulse after release.

Structure
REQ-026 FSM state enum SHALL be local; rggen_status and rggen_direction SHALL come from rggen_rtl_pkg; write-mask expansion function SHALL be added to rggen_rtl_pkg for reuse.
REQ-027 Selected-channel index/one-hot-to-binary logic SHALL be a sub-module rggen_onehot_mux (parameters WIDTH, ENTRIES; outputs selected entry and multi-hot flag).

Verification
REQ-028 Write 0xDEADBEEF, strobe 0xF, reg1 of 4 selects with ready same cycle -> write_done at N+2, status OKAY, reg1 write_mask 0xFFFFFFFF.
REQ-029 Read, reg0 selects, ready after 3 cycles, read_data 0x12345678 -> read_done at N+5, read_data 0x12345678, OKAY.
REQ-030 Read, no select -> done at N+2, read_data 0, DECODE_ERROR.
REQ-031 TIMEOUT_CYCLES=4, select held, ready never -> done at N+6, SLAVE_ERROR; repeat with ready in timeout cycle -> OKAY.
REQ-032 Two selects, MULTI_SELECT_ERROR=1 -> SLAVE_ERROR at N+2; =0 -> lower index data returned.
REQ-033 rst_n pulsed mid-ACCESS -> no done after release, all outputs at reset values, next request completes normally.
